// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready flow control and a 2-entry skid buffer.
// Optional illegal-format flag output enabled by defining IMM_GEN_ILLEGAL_EN.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [31:0]            inst_i,
  input  logic [TAG_W-1:0]       tag_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic signed [XLEN-1:0] imm_o,
  output logic [2:0]             fmt_o,
  output logic [TAG_W-1:0]       tag_o
`ifdef IMM_GEN_ILLEGAL_EN
  ,
  output logic                   illegal_o
`endif
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  function automatic logic [2:0] decode_fmt(input logic [6:0] opcode);
    logic [2:0] f;
    case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111: f = FMT_I;
      7'b0100011:                         f = FMT_S;
      7'b1100011:                         f = FMT_B;
      7'b0110111, 7'b0010111:             f = FMT_U;
      7'b1101111:                         f = FMT_J;
      default:                            f = FMT_NONE;
    endcase
    return f;
  endfunction

  // Build the 32-bit signed immediate, then widen; the signed size cast replicates inst[31].
  function automatic logic signed [XLEN-1:0] decode_imm(input logic [31:0] inst,
                                                        input logic [2:0]  fmt);
    logic signed [31:0] imm32;
    case (fmt)
      FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm32 = {inst[31:12], 12'b0};
      FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    return XLEN'(imm32);
  endfunction

  function automatic logic decode_illegal(input logic [31:0] inst, input logic [2:0] fmt);
    return (fmt == FMT_NONE) || (((fmt == FMT_B) || (fmt == FMT_J)) && inst[8]);
  endfunction

  // p0: combinational decode of the incoming instruction
  logic [2:0]             fmt_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic                   ill_p0;

  always_comb begin
    fmt_p0 = decode_fmt(inst_i[6:0]);
    imm_p0 = decode_imm(inst_i, fmt_p0);
    ill_p0 = decode_illegal(inst_i, fmt_p0);
  end

  // p1: OUT and SKID entries plus the occupancy FSM
  state_e state_p1, state_nxt;
  logic   vld_p1;
  logic   skid_vld_p1;
  logic   accept, drain;
  logic   load_out, load_skid, out_from_skid;

  logic signed [XLEN-1:0] imm_p1,  skid_imm_p1;
  logic [2:0]             fmt_p1,  skid_fmt_p1;
  logic [TAG_W-1:0]       tag_p1,  skid_tag_p1;
  logic                   ill_p1,  skid_ill_p1;

  assign vld_p1      = (state_p1 != ST_EMPTY);
  assign skid_vld_p1 = (state_p1 == ST_FULL);
  assign ready_o     = !skid_vld_p1;
  assign accept      = valid_i && ready_o;
  assign drain       = vld_p1 && ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_p1 <= ST_EMPTY;
    else       state_p1 <= state_nxt;
  end

  always_comb begin
    state_nxt     = state_p1;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state_p1)
      ST_EMPTY: begin
        if (accept) begin
          load_out  = 1'b1;
          state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && !drain) begin
          load_skid = 1'b1;
          state_nxt = ST_FULL;
        end else if (drain && !accept) begin
          state_nxt = ST_EMPTY;
        end else if (accept && drain) begin
          load_out  = 1'b1;
        end
      end
      ST_FULL: begin
        if (drain) begin
          out_from_skid = 1'b1;
          state_nxt     = ST_ONE;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // A flush empties both entries; any simultaneous accept is dropped.
    if (flush_i) begin
      state_nxt     = ST_EMPTY;
      load_out      = 1'b0;
      load_skid     = 1'b0;
      out_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      imm_p1      <= '0;
      fmt_p1      <= FMT_NONE;
      tag_p1      <= '0;
      ill_p1      <= 1'b0;
      skid_imm_p1 <= '0;
      skid_fmt_p1 <= FMT_NONE;
      skid_tag_p1 <= '0;
      skid_ill_p1 <= 1'b0;
    end else begin
      if (load_out) begin
        imm_p1 <= imm_p0;
        fmt_p1 <= fmt_p0;
        tag_p1 <= tag_i;
        ill_p1 <= ill_p0;
      end else if (out_from_skid) begin
        imm_p1 <= skid_imm_p1;
        fmt_p1 <= skid_fmt_p1;
        tag_p1 <= skid_tag_p1;
        ill_p1 <= skid_ill_p1;
      end
      if (load_skid) begin
        skid_imm_p1 <= imm_p0;
        skid_fmt_p1 <= fmt_p0;
        skid_tag_p1 <= tag_i;
        skid_ill_p1 <= ill_p0;
      end
    end
  end

  assign valid_o = vld_p1;
  assign imm_o   = imm_p1;
  assign fmt_o   = fmt_p1;
  assign tag_o   = tag_p1;

`ifdef IMM_GEN_ILLEGAL_EN
  assign illegal_o = ill_p1;
`else
  logic unused_ill;
  assign unused_ill = ^{ill_p1, skid_ill_p1};
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe: decode vectors, backpressure, flush and reset.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, valid_in, ready_in;
  logic [31:0] inst;
  logic [7:0]  tag;
  logic        ready_out, valid_out, ready_out64, valid_out64;
  logic [31:0] imm;
  logic [63:0] imm64;
  logic [2:0]  fmt, fmt64;
  logic [7:0]  tag_out, tag_out64;
`ifdef IMM_GEN_ILLEGAL_EN
  logic        illegal, illegal64;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_in), .ready_o(ready_out),
    .inst_i(inst), .tag_i(tag), .valid_o(valid_out), .ready_i(ready_in),
    .imm_o(imm), .fmt_o(fmt), .tag_o(tag_out)
`ifdef IMM_GEN_ILLEGAL_EN
    , .illegal_o(illegal)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_in), .ready_o(ready_out64),
    .inst_i(inst), .tag_i(tag), .valid_o(valid_out64), .ready_i(ready_in),
    .imm_o(imm64), .fmt_o(fmt64), .tag_o(tag_out64)
`ifdef IMM_GEN_ILLEGAL_EN
    , .illegal_o(illegal64)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; valid_in = 1'b0; inst = 32'h0; tag = 8'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ready_in = 1'b0;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
    tests++;
    if (valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", valid_out); end
    tests++;
    if (ready_out !== 1'b1) begin fails++; $display("FAIL reset_ready got %0b want 1", ready_out); end
    tests++;
    if ({imm, fmt, tag_out} !== 43'h0) begin
      fails++; $display("FAIL reset_data imm=%h fmt=%0d tag=%h want all 0", imm, fmt, tag_out);
    end
    tests++;
    if (imm64 !== 64'h0) begin fails++; $display("FAIL reset_imm64 got %h want 0", imm64); end
  endtask

  task automatic test_decode();
    logic [31:0] v_inst [8];
    logic [31:0] v_imm  [8];
    logic [63:0] v_imm64[8];
    logic [2:0]  v_fmt  [8];
    logic        v_ill  [8];
    v_inst[0] = 32'hFFF00093; v_imm[0] = 32'hFFFFFFFF; v_imm64[0] = 64'hFFFF_FFFF_FFFF_FFFF; v_fmt[0] = 3'd1; v_ill[0] = 1'b0;
    v_inst[1] = 32'hFE112E23; v_imm[1] = 32'hFFFFFFFC; v_imm64[1] = 64'hFFFF_FFFF_FFFF_FFFC; v_fmt[1] = 3'd2; v_ill[1] = 1'b0;
    v_inst[2] = 32'hFE000CE3; v_imm[2] = 32'hFFFFFFF8; v_imm64[2] = 64'hFFFF_FFFF_FFFF_FFF8; v_fmt[2] = 3'd3; v_ill[2] = 1'b0;
    v_inst[3] = 32'h123452B7; v_imm[3] = 32'h12345000; v_imm64[3] = 64'h0000_0000_1234_5000; v_fmt[3] = 3'd4; v_ill[3] = 1'b0;
    v_inst[4] = 32'h0010006F; v_imm[4] = 32'h00000800; v_imm64[4] = 64'h0000_0000_0000_0800; v_fmt[4] = 3'd5; v_ill[4] = 1'b0;
    v_inst[5] = 32'h0000007F; v_imm[5] = 32'h00000000; v_imm64[5] = 64'h0;                   v_fmt[5] = 3'd0; v_ill[5] = 1'b1;
    v_inst[6] = 32'h7FF00067; v_imm[6] = 32'h000007FF; v_imm64[6] = 64'h0000_0000_0000_07FF; v_fmt[6] = 3'd1; v_ill[6] = 1'b0;
    v_inst[7] = 32'hF0000037; v_imm[7] = 32'hF0000000; v_imm64[7] = 64'hFFFF_FFFF_F000_0000; v_fmt[7] = 3'd4; v_ill[7] = 1'b0;
    ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      valid_in = 1'b1; inst = v_inst[i]; tag = 8'h11 + 8'(i);
      tick();
      idle_inputs();
      tests++;
      if (valid_out !== 1'b1 || tag_out !== 8'h11 + 8'(i)) begin
        fails++; $display("FAIL dec%0d_vld_tag valid=%0b tag=%h want 1 %h", i, valid_out, tag_out, 8'h11 + 8'(i));
      end
      tests++;
      if (imm !== v_imm[i] || fmt !== v_fmt[i]) begin
        fails++; $display("FAIL dec%0d_imm32 imm=%h fmt=%0d want %h %0d", i, imm, fmt, v_imm[i], v_fmt[i]);
      end
      tests++;
      if (imm64 !== v_imm64[i] || fmt64 !== v_fmt[i]) begin
        fails++; $display("FAIL dec%0d_imm64 imm=%h fmt=%0d want %h %0d", i, imm64, fmt64, v_imm64[i], v_fmt[i]);
      end
`ifdef IMM_GEN_ILLEGAL_EN
      tests++;
      if (illegal !== v_ill[i] || illegal64 !== v_ill[i]) begin
        fails++; $display("FAIL dec%0d_illegal got %0b/%0b want %0b", i, illegal, illegal64, v_ill[i]);
      end
`endif
      tick();
      tests++;
      if (valid_out !== 1'b0) begin fails++; $display("FAIL dec%0d_drain valid=%0b want 0", i, valid_out); end
    end
  endtask

  task automatic test_back_to_back();
    ready_in = 1'b0;
    valid_in = 1'b1; inst = 32'h00100093; tag = 8'hA1;
    tick();
    tests++;
    if (ready_out !== 1'b1 || valid_out !== 1'b1) begin
      fails++; $display("FAIL b2b_first ready=%0b valid=%0b want 1 1", ready_out, valid_out);
    end
    inst = 32'h00200093; tag = 8'hA2;
    tick();
    tests++;
    if (ready_out !== 1'b0) begin fails++; $display("FAIL b2b_full_ready got %0b want 0", ready_out); end
    inst = 32'h00300093; tag = 8'hA3;
    tick();
    tests++;
    if (ready_out !== 1'b0 || tag_out !== 8'hA1 || imm !== 32'h1) begin
      fails++; $display("FAIL b2b_hold ready=%0b tag=%h imm=%h want 0 a1 1", ready_out, tag_out, imm);
    end
    ready_in = 1'b1;
    tick();
    tests++;
    if (valid_out !== 1'b1 || tag_out !== 8'hA2 || imm !== 32'h2 || ready_out !== 1'b1) begin
      fails++; $display("FAIL b2b_out2 valid=%0b tag=%h imm=%h ready=%0b want 1 a2 2 1", valid_out, tag_out, imm, ready_out);
    end
    tick();
    idle_inputs();
    tests++;
    if (valid_out !== 1'b1 || tag_out !== 8'hA3 || imm !== 32'h3) begin
      fails++; $display("FAIL b2b_out3 valid=%0b tag=%h imm=%h want 1 a3 3", valid_out, tag_out, imm);
    end
    tick();
    tests++;
    if (valid_out !== 1'b0) begin fails++; $display("FAIL b2b_empty valid=%0b want 0 (duplicate)", valid_out); end
  endtask

  task automatic test_throughput();
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1; inst = 32'h00000013 | (32'(i) << 20); tag = 8'hC0 + 8'(i);
      tick();
      tests++;
      if (valid_out !== 1'b1 || tag_out !== 8'hC0 + 8'(i) || imm !== 32'(i) || ready_out !== 1'b1) begin
        fails++; $display("FAIL stream%0d valid=%0b tag=%h imm=%h ready=%0b want 1 %h %0d 1",
                          i, valid_out, tag_out, imm, ready_out, 8'hC0 + 8'(i), i);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic fill_full();
    ready_in = 1'b0;
    valid_in = 1'b1; inst = 32'hFFF00093; tag = 8'h51;
    tick();
    tag = 8'h52;
    tick();
  endtask

  task automatic test_flush();
    fill_full();
    tests++;
    if (ready_out !== 1'b0) begin fails++; $display("FAIL flush_setup ready=%0b want 0", ready_out); end
    tag = 8'h99; flush = 1'b1;
    tick();
    flush = 1'b0; valid_in = 1'b0;
    tests++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
      fails++; $display("FAIL flush_full valid=%0b ready=%0b want 0 1", valid_out, ready_out);
    end
    ready_in = 1'b1;
    tick(); tick();
    tests++;
    if (valid_out !== 1'b0) begin fails++; $display("FAIL flush_leak valid=%0b tag=%h want 0", valid_out, tag_out); end
    valid_in = 1'b1; inst = 32'h00500093; tag = 8'h61;
    tick();
    tag = 8'h62; flush = 1'b1;
    tick();
    idle_inputs();
    tests++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
      fails++; $display("FAIL flush_accept valid=%0b ready=%0b want 0 1", valid_out, ready_out);
    end
  endtask

  task automatic test_reset_mid();
    fill_full();
    tag = 8'h99; flush = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    tests++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1 || imm !== 32'h0 || fmt !== 3'd0 || tag_out !== 8'h0) begin
      fails++; $display("FAIL reset_mid valid=%0b ready=%0b imm=%h fmt=%0d tag=%h want 0 1 0 0 0",
                        valid_out, ready_out, imm, fmt, tag_out);
    end
    ready_in = 1'b1;
    tick();
    tests++;
    if (valid_out !== 1'b0) begin fails++; $display("FAIL reset_mid_leak valid=%0b want 0", valid_out); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_throughput();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
